// File: rtl/key_debounce_if.sv
// Key bundle between the raw key pins, the debouncer and the control logic.
// Ports: key_n (raw, active-low), key_state/key_press/key_release/key_long.
interface key_debounce_if;
   logic [1:0] key_n;
   logic [1:0] key_state;
   logic [1:0] key_press;
   logic [1:0] key_release;
   logic [1:0] key_long;

   // master: the debouncer, which produces the key events
   modport master (
      input  key_n,
      output key_state,
      output key_press,
      output key_release,
      output key_long
   );

   // slave: the board pins and the consumer of the key events
   modport slave (
      output key_n,
      input  key_state,
      input  key_press,
      input  key_release,
      input  key_long
   );
endinterface

// File: rtl/key_debounce.sv
// Two-key debouncer: 2-flop sync, per-key debounce FSM, press/release pulses.
// Ports: clk, rst_n (async, active-low), bus (key_debounce_if.master).
// Optional long-press detection is built when KEY_LONG_PRESS_EN is defined;
// otherwise key_long is tied to 2'b00.
module key_debounce #(
   parameter DEBOUNCE_CNT = 25'd1000_000,
   parameter LONG_CNT     = 26'd50_000_000
) (
   input  logic           clk,
   input  logic           rst_n,
   key_debounce_if.master bus
);

   if (DEBOUNCE_CNT < 2 || LONG_CNT < 2) begin : g_bad_param
      $error("key_debounce: DEBOUNCE_CNT and LONG_CNT must be >= 2");
   end

   localparam int DW = $clog2(DEBOUNCE_CNT);
   localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CNT - 1);

   localparam logic [1:0] IDLE       = 2'd0;
   localparam logic [1:0] PRESS_DB   = 2'd1;
   localparam logic [1:0] PRESSED    = 2'd2;
   localparam logic [1:0] RELEASE_DB = 2'd3;

   logic [1:0] sync1_q, sync1_d;
   logic [1:0] sync2_q, sync2_d;

   logic [1:0][1:0]    st_q, st_d;
   logic [1:0][DW-1:0] dcnt_q, dcnt_d;
   logic [1:0]         state_q, state_d;
   logic [1:0]         press_q, press_d;
   logic [1:0]         rel_q, rel_d;

   // synchronizer: both stages idle at 1 (released)
   always_comb begin
      sync1_d = bus.key_n;
      sync2_d = sync1_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 2'b11;
         sync2_q <= 2'b11;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   always_comb begin
      st_d    = st_q;
      dcnt_d  = dcnt_q;
      state_d = state_q;
      press_d = 2'b00;
      rel_d   = 2'b00;
      for (int i = 0; i < 2; i++) begin
         case (st_q[i])
            IDLE: begin
               if (!sync2_q[i]) begin
                  st_d[i]   = PRESS_DB;
                  dcnt_d[i] = '0;
               end
            end
            PRESS_DB: begin
               if (sync2_q[i]) begin
                  st_d[i] = IDLE;
               end else if (dcnt_q[i] == DMAX) begin
                  st_d[i]    = PRESSED;
                  press_d[i] = 1'b1;
                  state_d[i] = 1'b1;
               end else begin
                  dcnt_d[i] = dcnt_q[i] + 1'b1;
               end
            end
            PRESSED: begin
               if (sync2_q[i]) begin
                  st_d[i]   = RELEASE_DB;
                  dcnt_d[i] = '0;
               end
            end
            RELEASE_DB: begin
               if (!sync2_q[i]) begin
                  st_d[i] = PRESSED;
               end else if (dcnt_q[i] == DMAX) begin
                  st_d[i]    = IDLE;
                  rel_d[i]   = 1'b1;
                  state_d[i] = 1'b0;
               end else begin
                  dcnt_d[i] = dcnt_q[i] + 1'b1;
               end
            end
            default: begin
               st_d[i]    = IDLE;
               dcnt_d[i]  = '0;
               state_d[i] = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q    <= {IDLE, IDLE};
         dcnt_q  <= '0;
         state_q <= 2'b00;
         press_q <= 2'b00;
         rel_q   <= 2'b00;
      end else begin
         st_q    <= st_d;
         dcnt_q  <= dcnt_d;
         state_q <= state_d;
         press_q <= press_d;
         rel_q   <= rel_d;
      end
   end

   assign bus.key_state   = state_q;
   assign bus.key_press   = press_q;
   assign bus.key_release = rel_q;

`ifdef KEY_LONG_PRESS_EN
   localparam int LW = $clog2(LONG_CNT);
   localparam logic [LW-1:0] LMAX = LW'(LONG_CNT - 1);

   logic [1:0][LW-1:0] lcnt_q, lcnt_d;
   logic [1:0]         lfired_q, lfired_d;
   logic [1:0]         long_q, long_d;

   // lcnt saturates at LMAX; lfired keeps it to one pulse per press
   always_comb begin
      lcnt_d   = lcnt_q;
      lfired_d = lfired_q;
      long_d   = 2'b00;
      for (int i = 0; i < 2; i++) begin
         if (st_q[i] == PRESS_DB && st_d[i] == PRESSED) begin
            lcnt_d[i]   = '0;
            lfired_d[i] = 1'b0;
         end else if (st_q[i] == PRESSED) begin
            if (lcnt_q[i] == LMAX) begin
               if (!lfired_q[i]) begin
                  long_d[i]   = 1'b1;
                  lfired_d[i] = 1'b1;
               end
            end else begin
               lcnt_d[i] = lcnt_q[i] + 1'b1;
            end
         end else if (st_q[i] == IDLE) begin
            lcnt_d[i]   = '0;
            lfired_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lcnt_q   <= '0;
         lfired_q <= 2'b00;
         long_q   <= 2'b00;
      end else begin
         lcnt_q   <= lcnt_d;
         lfired_q <= lfired_d;
         long_q   <= long_d;
      end
   end

   assign bus.key_long = long_q;
`else
   assign bus.key_long = 2'b00;
`endif

endmodule

// File: doc/key_debounce.md
# key_debounce

Input-side companion to the LED rotator: conditions the board's two active-low push-buttons into clean, debounced levels and single-cycle press/release events. Each key is synchronized, filtered by a per-key debounce state machine, and optionally monitored for long presses. It sits between the raw key pins and the control logic that updates the LED pattern.

## Interface

Parameters:
- `DEBOUNCE_CNT`, default `25'd1000_000`: stable-level cycles needed to accept a change; 20 ms at 50 MHz; minimum 2.
- `LONG_CNT`, default `26'd50_000_000`: cycles held in PRESSED before `key_long` fires; 1 s at 50 MHz; minimum 2.

Ports (one clock, `clk`; reset `rst_n`, asynchronous, active-low):
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous active-low reset.
- `key_n` input 2: raw key pins, asynchronous, 0 = pressed.
- `key_state` output 2: debounced level per key, 1 = pressed.
- `key_press` output 2: one-cycle pulse per key on an accepted press.
- `key_release` output 2: one-cycle pulse per key on an accepted release.
- `key_long` output 2: one-cycle pulse per key on a long press; constant 0 when `KEY_LONG_PRESS_EN` is undefined.

## Operation

- Per key, a 2-flop synchronizer samples `key_n[i]`. Both flops reset to 1 (released). The FSM sees only the second flop, `s[i]`.
- Each key has an independent FSM with a debounce counter `dcnt`, sized by `$clog2(DEBOUNCE_CNT)`.
- IDLE: stable released state.
  - `s=0` → PRESS_DB, `dcnt<=0`.
- PRESS_DB:
  - `s=1` → IDLE. This is a bounce; no event is generated.
  - Else, if `dcnt==DEBOUNCE_CNT-1` → PRESSED. Register `key_press[i]=1` for one cycle and set `key_state[i]=1`.
  - Else `dcnt++`.
- PRESSED:
  - `s=1` → RELEASE_DB, `dcnt<=0`.
- RELEASE_DB:
  - `s=0` → PRESSED. This is a bounce; no event, and `key_state` stays 1.
  - Else, if `dcnt==DEBOUNCE_CNT-1` → IDLE. Register `key_release[i]=1` for one cycle and set `key_state[i]=0`.
  - Else `dcnt++`.
- `key_state` is registered and changes on the same edge as the matching pulse.
- Keys are fully independent. Simultaneous events on both keys produce simultaneous pulses on both bits.
- Encoding: `dcnt` never exceeds `DEBOUNCE_CNT-1`, so there is no wrap. Unused FSM encodings recover to IDLE.

## Timing

- Reset value of every output is 0. All FSMs reset to IDLE, all counters to 0, and the synchronizers to 1.
- Press latency: count the first edge that samples `key_n[i]` low, held stable, as edge 0.
  - The FSM enters PRESS_DB at edge 2.
  - `key_press[i]` and `key_state[i]` go high after edge `DEBOUNCE_CNT+2`.
  - Release latency is identical, measured from the first sampled high.
- Any opposite level seen in a DB state aborts that DB state on the same edge. A subsequent attempt restarts `dcnt` from 0.
- Pulses are exactly one cycle wide and never repeat without a full state change.
- `rst_n` asserted mid-debounce or mid-press clears state immediately, without a release pulse.
- After reset deassertion, a key held low produces a normal press event `DEBOUNCE_CNT+2` edges after the first sampling edge.

## Configuration

- Macro `KEY_LONG_PRESS_EN`, defined: each key gets a long counter `lcnt`, sized by `$clog2(LONG_CNT)`.
  - `lcnt` is cleared on the transition PRESS_DB→PRESSED.
  - It increments in PRESSED and holds in RELEASE_DB, so a bounce back to PRESSED resumes the count.
  - When `lcnt==LONG_CNT-1` in PRESSED, `key_long[i]` pulses for one cycle and `lcnt` saturates. There is at most one long pulse per press.
  - `lcnt` is cleared in IDLE.
- Macro `KEY_LONG_PRESS_EN`, undefined: no long counters are built and `key_long` is tied to 2'b00. All other behaviour is identical.

## Test plan

All scenarios use `DEBOUNCE_CNT=8` and `LONG_CNT=40`.

- Reset: hold `rst_n=0` with `key_n=2'b00` → all outputs 0. Release reset and keep keys low → `key_press=2'b11` pulses once, exactly 10 edges after the first sampling edge, and `key_state=2'b11`.
- Clean press/release on key0: `key_n[0]` low 20 cycles, then high → `key_press[0]` at edge 10, one cycle wide. `key_release[0]` 10 edges after the rising sample, `key_state[0]` returns to 0, and key1 outputs stay 0.
- Bounce rejection: toggle `key_n[1]` low/high every 3 cycles for 30 cycles, then hold high → no pulses and `key_state[1]=0` throughout. Glitch `key_n[0]` high for 2 cycles during PRESSED → no release pulse and `key_state[0]` stays 1.
- Long press (macro defined): hold key0 low for 60 cycles → `key_long[0]` pulses exactly once, 40 cycles after `key_press[0]`. Repeat with the macro undefined → `key_long` stays 0.
- Reset mid-operation: assert `rst_n` 4 cycles into PRESS_DB and again during PRESSED → outputs go 0 immediately with no release pulse. After deassertion with the key still low → a fresh `key_press` arrives after 10 edges.
